imem_loader: RTL

- Write-side counterpart of the byte-addressed instruction memory.
- Accepts 32-bit instruction words over a valid/ready stream (boot/test loader) and writes them into the instruction memory byte array through a single-byte write port. Bytes are written little-endian: word bits [7:0] go to address A+0 and bits [31:24] go to A+3.
- Tracks the fill pointer, reports completion, and blocks further writes once the memory is full.

---
 rtl/imem_loader.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//
// Purpose:
//   Write-side companion of the byte-addressed instruction memory. Takes
//   32-bit instruction words from a valid/ready stream (boot or test loader)
//   and writes each one into memory through a single-byte write port. The
//   word is written little-endian: bits [7:0] go to address A+0 and bits
//   [31:24] go to A+3. A fill pointer advances by 4 per word. The block
//   reports the end of a session and refuses further words once the memory
//   is full.
//
// Parameters:
//   MEM_BYTES  instruction memory size in bytes (multiple of 4, >= 4)
//   BASE_ADDR  byte address of the first word written (4-byte aligned)
//   CNT_W      width of word_count
//
// Ports:
//   clk         in   system clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   start       in   one-cycle pulse that opens a load session
//   word_valid  in   source presents a word on word_data
//   word_data   in   32-bit instruction word
//   word_last   in   marks the final word of the session
//   word_ready  out  loader accepts a word this cycle
//   wr_en       out  byte write strobe to the instruction memory
//   wr_addr     out  64-bit byte address
//   wr_byte     out  byte data
//   busy        out  session in progress (accepting or writing)
//   done        out  one-cycle pulse at the end of a session
//   full        out  memory full, held until the next start or reset
//   word_count  out  words written in the current session (saturating)
//
// All outputs are registered.
// ---------------------------------------------------------------------------
module imem_loader #(
  parameter int unsigned MEM_BYTES = 16,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             word_valid,
  input  logic [31:0]      word_data,
  input  logic             word_last,
  output logic             word_ready,
  output logic             wr_en,
  output logic [63:0]      wr_addr,
  output logic [7:0]       wr_byte,
  output logic             busy,
  output logic             done,
  output logic             full,
  output logic [CNT_W-1:0] word_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEPT = 2'd1,
    WRITE  = 2'd2,
    FULL   = 2'd3
  } state_t;

  localparam logic [63:0] LP_BASE = 64'(BASE_ADDR);
  // First address past the memory; the pointer reaching it means full.
  localparam logic [63:0] LP_END  = 64'(BASE_ADDR) + 64'(MEM_BYTES);

  state_t           r_state;
  logic [63:0]      r_ptr;
  logic [31:0]      r_word;
  logic             r_last;
  logic [1:0]       r_byteIdx;
  logic             r_wordReady;
  logic             r_wrEn;
  logic [63:0]      r_wrAddr;
  logic [7:0]       r_wrByte;
  logic             r_busy;
  logic             r_done;
  logic             r_full;
  logic [CNT_W-1:0] r_wordCount;

  logic [1:0]       w_nextIdx;
  logic [7:0]       w_nextByte;
  logic [63:0]      w_ptrNext;
  logic [CNT_W-1:0] w_countNext;

  // The output registers always hold the byte being written in the current
  // cycle. The logic below looks one byte ahead so the next byte can be
  // loaded on the clock edge.
  assign w_nextIdx   = r_byteIdx + 2'd1;
  assign w_nextByte  = r_word[{w_nextIdx, 3'b000} +: 8];
  assign w_ptrNext   = r_ptr + 64'd4;
  assign w_countNext = (r_wordCount == {CNT_W{1'b1}}) ? r_wordCount
                                                      : r_wordCount + CNT_W'(1);

  // Single FSM with registered outputs. The handshake edge already presents
  // byte 0, so wr_en covers exactly the four cycles after the handshake. The
  // edge that retires byte 3 also updates the pointer, the count and the
  // next state, so word_ready returns in the fifth cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_ptr       <= LP_BASE;
      r_word      <= '0;
      r_last      <= 1'b0;
      r_byteIdx   <= '0;
      r_wordReady <= 1'b0;
      r_wrEn      <= 1'b0;
      r_wrAddr    <= '0;
      r_wrByte    <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_full      <= 1'b0;
      r_wordCount <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        // IDLE and FULL both open a new session on start. In FULL, start is
        // the only way out; word_valid alone is ignored.
        IDLE, FULL: begin
          if (start) begin
            r_state     <= ACCEPT;
            r_ptr       <= LP_BASE;
            r_wordCount <= '0;
            r_full      <= 1'b0;
            r_wordReady <= 1'b1;
            r_busy      <= 1'b1;
          end
        end

        ACCEPT: begin
          if (word_valid && r_wordReady) begin
            r_word      <= word_data;
            r_last      <= word_last;
            r_byteIdx   <= 2'd0;
            r_wrEn      <= 1'b1;
            r_wrAddr    <= r_ptr;
            r_wrByte    <= word_data[7:0];
            r_wordReady <= 1'b0;
            r_state     <= WRITE;
          end
        end

        WRITE: begin
          if (r_byteIdx != 2'd3) begin
            r_byteIdx <= w_nextIdx;
            r_wrAddr  <= r_ptr + {62'd0, w_nextIdx};
            r_wrByte  <= w_nextByte;
          end else begin
            r_wrEn      <= 1'b0;
            r_ptr       <= w_ptrNext;
            r_wordCount <= w_countNext;
            r_done      <= 1'b1;
            // A full memory takes priority over word_last. Both cases end
            // the session with the same single done pulse.
            if (w_ptrNext == LP_END) begin
              r_state <= FULL;
              r_full  <= 1'b1;
              r_busy  <= 1'b0;
            end else if (r_last) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state     <= ACCEPT;
              r_wordReady <= 1'b1;
              r_done      <= 1'b0;
            end
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign word_ready = r_wordReady;
  assign wr_en      = r_wrEn;
  assign wr_addr    = r_wrAddr;
  assign wr_byte    = r_wrByte;
  assign busy       = r_busy;
  assign done       = r_done;
  assign full       = r_full;
  assign word_count = r_wordCount;

endmodule
